// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: formats load data, selects the writeback value and
// presents {rd, we, data} to the register file through a single-entry valid/ready slot.
module mem_wb_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic [XLEN-1:0]       alu_result,
   input  logic [XLEN-1:0]       mem_rdata,
   input  logic                  mem_read,
   input  logic [2:0]            funct3,
   input  logic [XLEN-1:0]       pc_plus4,
   input  logic [1:0]            wb_sel,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic                  reg_write,
   input  logic                  wb_ready,
   output logic                  wb_valid,
   output logic                  wb_we,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [XLEN-1:0]       wb_data,
   output logic                  load_misalign,
   output logic [CNT_W-1:0]      retire_cnt
);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic                  r_valid;
   logic                  r_we;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [XLEN-1:0]       r_data;
   logic                  r_misalign;
   logic [CNT_W-1:0]      r_retire_cnt;

   logic [1:0]            w_off;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [XLEN-1:0]       w_load;
   logic                  w_misalign;
   logic [XLEN-1:0]       w_wb_data;
   logic                  w_we;
   logic                  w_accept;
   logic                  w_complete;
   logic                  w_valid_next;
   logic                  w_unused_addr;

   assign w_off         = alu_result[1:0];
   assign w_unused_addr = ^alu_result[XLEN-1:2];

   always_comb begin
      w_byte = mem_rdata[7:0];
      case (w_off)
         2'd0: w_byte = mem_rdata[7:0];
         2'd1: w_byte = mem_rdata[15:8];
         2'd2: w_byte = mem_rdata[23:16];
         2'd3: w_byte = mem_rdata[31:24];
         default: w_byte = mem_rdata[7:0];
      endcase
      w_half = w_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   // Misalignment and reserved encodings only matter for real loads.
   always_comb begin
      w_misalign = 1'b0;
      w_load     = '0;
      case (funct3)
         F3_LB:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU: w_load = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH: begin
            w_load     = {{(XLEN-16){w_half[15]}}, w_half};
            w_misalign = mem_read & w_off[0];
         end
         F3_LHU: begin
            w_load     = {{(XLEN-16){1'b0}}, w_half};
            w_misalign = mem_read & w_off[0];
         end
         F3_LW: begin
            w_load     = mem_rdata;
            w_misalign = mem_read & (w_off != 2'd0);
         end
         default: begin
            w_load     = '0;
            w_misalign = mem_read;
         end
      endcase
      if (w_misalign) begin
         w_load = '0;
      end
   end

   always_comb begin
      w_wb_data = '0;
      case (wb_sel)
         2'b00:   w_wb_data = alu_result;
         2'b01:   w_wb_data = w_load;
         2'b10:   w_wb_data = pc_plus4;
         default: w_wb_data = '0;
      endcase
   end

   assign w_we       = reg_write & (rd != '0) & ~w_misalign;
   assign in_ready   = ~r_valid | wb_ready;
   assign w_accept   = in_valid & in_ready & ~flush;
   assign w_complete = r_valid & wb_ready;

   // Flush wins over a same-cycle accept; a completing entry still retires.
   always_comb begin
      if (flush) begin
         w_valid_next = 1'b0;
      end else if (w_accept) begin
         w_valid_next = 1'b1;
      end else if (w_complete) begin
         w_valid_next = 1'b0;
      end else begin
         w_valid_next = r_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_we         <= 1'b0;
         r_rd         <= '0;
         r_data       <= '0;
         r_misalign   <= 1'b0;
         r_retire_cnt <= '0;
      end else begin
         r_valid <= w_valid_next;
         if (w_accept) begin
            r_we       <= w_we;
            r_rd       <= rd;
            r_data     <= w_wb_data;
            r_misalign <= w_misalign;
         end
         if (w_complete) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
         end
      end
   end

   assign wb_valid      = r_valid;
   assign wb_we         = r_we;
   assign wb_rd         = r_rd;
   assign wb_data       = r_data;
   assign load_misalign = r_misalign;
   assign retire_cnt    = r_retire_cnt;

endmodule
